// File: rtl/inert_poll_ctrl.sv
// Yaw-rate sensor poll controller: waits after reset, writes the sensor configuration
// over a 16-bit SPI master, then reads the yaw-rate register pair on each data-ready INT.
module inert_poll_ctrl #(
  parameter logic [15:0] INIT_WAIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld
);

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CMD_W-1:0] CMD_RD_YAW_L = 16'hA600;
  localparam logic [CMD_W-1:0] CMD_RD_YAW_H = 16'hA700;
  localparam logic [IDX_W-1:0] IDX_LAST     = 2'd3;

  typedef enum logic [2:0] {
    S_INIT_WAIT = 3'd0,
    S_CFG       = 3'd1,
    S_CFG_WT    = 3'd2,
    S_IDLE      = 3'd3,
    S_RD_L      = 3'd4,
    S_RD_L_WT   = 3'd5,
    S_RD_H      = 3'd6,
    S_RD_H_WT   = 3'd7
  } state_e;

  // Sensor configuration words, written in index order.
  function automatic logic [CMD_W-1:0] cfg_word(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    cfg_word = 16'h0D02;
      2'd1:    cfg_word = 16'h1062;
      2'd2:    cfg_word = 16'h1162;
      default: cfg_word = 16'h1460;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pend_q, pend_d;
  logic [BYTE_W-1:0]  lo_q, lo_d;
  logic               wrt_q, wrt_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [CMD_W-1:0]   yaw_q, yaw_d;
  logic               vld_q, vld_d;

  logic               int_meta_q, int_sync_q, int_sync_dly_q;
  logic               done_dly_q;
  logic               int_evt;
  logic               done_edge;
  logic               rd_hi_unused;

  // Two-flop synchroniser on INT plus a delay flop for its rising-edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_meta_q     <= 1'b0;
      int_sync_q     <= 1'b0;
      int_sync_dly_q <= 1'b0;
      done_dly_q     <= 1'b0;
    end else begin
      int_meta_q     <= INT;
      int_sync_q     <= int_meta_q;
      int_sync_dly_q <= int_sync_q;
      done_dly_q     <= done;
    end
  end

  assign int_evt      = int_sync_q & ~int_sync_dly_q;
  // A held-high done never counts; only a fresh rising edge completes a transfer.
  assign done_edge    = done & ~done_dly_q;
  assign rd_hi_unused = ^rd_data[CMD_W-1:BYTE_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      lo_q    <= '0;
      wrt_q   <= 1'b0;
      cmd_q   <= '0;
      yaw_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      lo_q    <= lo_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      yaw_q   <= yaw_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state and registered-output logic; cmd only changes alongside a wrt pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    lo_d    = lo_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    yaw_d   = yaw_q;
    vld_d   = 1'b0;

    if (int_evt && (state_q != S_IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_INIT_WAIT: begin
        if (cnt_q == INIT_WAIT) begin
          state_d = S_CFG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CFG: begin
        wrt_d   = 1'b1;
        cmd_d   = cfg_word(idx_q);
        state_d = S_CFG_WT;
      end
      S_CFG_WT: begin
        if (done_edge) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_CFG;
          end
        end
      end
      S_IDLE: begin
        // A simultaneous INT event and pending flag start a single read.
        if (int_evt || pend_q) begin
          pend_d  = 1'b0;
          state_d = S_RD_L;
        end
      end
      S_RD_L: begin
        wrt_d   = 1'b1;
        cmd_d   = CMD_RD_YAW_L;
        state_d = S_RD_L_WT;
      end
      S_RD_L_WT: begin
        if (done_edge) begin
          lo_d    = rd_data[BYTE_W-1:0];
          state_d = S_RD_H;
        end
      end
      S_RD_H: begin
        wrt_d   = 1'b1;
        cmd_d   = CMD_RD_YAW_H;
        state_d = S_RD_H_WT;
      end
      S_RD_H_WT: begin
        if (done_edge) begin
          yaw_d   = {rd_data[BYTE_W-1:0], lo_q};
          vld_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT_WAIT;
      end
    endcase
  end

  assign wrt    = wrt_q;
  assign cmd    = cmd_q;
  assign yaw_rt = yaw_q;
  assign vld    = vld_q;

endmodule
